dff_share_arbiter: RTL and testbench
====================================

# dff_share_arbiter

Round-robin write arbiter and sequencer for a shared WIDTH-bit enabled-flip-flop register. Up to N_REQ requesters compete to load the register. The block grants one requester per write, drives the register's enable and data for exactly one cycle, then enforces a programmable cooldown before the next grant. It sits between requester blocks and the shared state register, and owns that register internally.

## Interface
- N_REQ, 4: number of requesters, 2..8.
- WIDTH, 8: register width in bits.
- GAP, 1: cooldown cycles after each write, 0..15.
- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  reset, synchronous, active-low; sampled on the clk rising edge.
- req  in  N_REQ  per-requester write request; bit i belongs to requester i.
- wdata  in  N_REQ*WIDTH  requester i's data in slice [i*WIDTH +: WIDTH].
- gnt  out  N_REQ  one-hot grant, asserted for exactly one cycle per write.
- wr_en  out  1  enable currently applied to the register; equals OR of gnt.
- q  out  WIDTH  shared register contents.
- owner  out  $clog2(N_REQ)  index of the last requester that wrote q.
- busy  out  1  high in GRANT and COOLDOWN states.

## Operation
- Reset: when rst=0 at a rising edge, the block enters IDLE with:
  - q=0, owner=0, gnt=0, wr_en=0, busy=0.
  - Round-robin pointer ptr=0, cooldown counter=0.
  - The latched data register is cleared.
- FSM states: IDLE, GRANT, COOLDOWN.
- IDLE:
  - If any req bit is 1 at the edge, select the winner.
  - Winner is the first set req bit searching ptr, ptr+1, ... with modulo-N_REQ wrap.
  - On that edge: latch wdata[winner] into the data register, set gnt to one-hot(winner), go to GRANT.
  - If no req bit is set, stay in IDLE with all outputs quiet.
- GRANT (exactly one cycle): gnt=one-hot(winner), wr_en=1, busy=1. On the closing edge:
  - q <= latched data; owner <= winner.
  - ptr <= (winner+1) mod N_REQ.
  - gnt <= 0.
  - Go to COOLDOWN with counter=GAP-1 if GAP>0, otherwise go to IDLE.
- COOLDOWN: busy=1, gnt=0, wr_en=0, and req is ignored.
  - When counter=0 at an edge, go to IDLE.
  - Otherwise decrement the counter.
- q changes only at the edge that closes GRANT. With wr_en=0, q holds its value (enabled-flop hold).
- Requester protocol:
  - Hold req until gnt is observed high.
  - Drop req in the cycle after gnt unless another write is wanted.
  - A req still high after its grant is re-arbitrated normally. The advanced ptr gives other requesters priority first.
- Dropping req before the IDLE sampling edge is legal; that requester is simply not granted.
- wdata is sampled only at the grant-decision edge. Later changes do not affect the write in progress.

## Timing
- Latency: req sampled at edge k in IDLE → gnt/wr_en high during cycle k..k+1 → q updated at edge k+1.
- Write-to-write spacing is GAP+2 cycles under continuous requests. With GAP=0 it is 2 cycles: IDLE decision, then GRANT.
- Reset mid-GRANT: a reset at the edge closing GRANT aborts the write. q=0 after that edge, not the latched data.
- Reset mid-COOLDOWN: the next cycle is IDLE with all outputs at reset values.
- Simultaneous requests: exactly one grant per decision, with strict rotation by ptr. No requester waits more than N_REQ-1 grants.
- ptr wrap: a winner at N_REQ-1 sets ptr=0.

## Test plan
1. Reset: drive rst=0 for 2 edges with req=4'b1111 → q=0, gnt=0, wr_en=0, busy=0, owner=0. Release rst → first grant goes to requester 0.
2. Single write: req=4'b0100 with wdata[2]=8'hA5 at edge k → gnt=4'b0100 and wr_en=1 during cycle k; q=8'hA5 and owner=2 after edge k+1; busy for GAP=1 more cycle.
3. Round-robin: hold req=4'b1111 with data 8'h10, 8'h21, 8'h32, 8'h43 → grant order 0,1,2,3,0; q sequence 10,21,32,43,10; grants spaced 3 cycles apart.
4. Cooldown ignore: assert req=4'b0010 during COOLDOWN only, then drop it before IDLE → no grant; q unchanged.
5. Reset mid-GRANT: grant requester 1 with 8'hFF and assert rst=0 at the closing edge → q=0, gnt=0, state IDLE.
6. Data sampling: change wdata[3] from 8'h55 to 8'hAA during GRANT → q=8'h55.

Source files
------------

// File: rtl/dff_share_arbiter_if.sv
// Bundle between requester blocks and the shared-register arbiter.
// The master side drives requests and data. The slave side returns the
// grant, the register contents and the ownership information.
interface dff_share_arbiter_if #(
  parameter int N_REQ = 4,
  parameter int WIDTH = 8
);
  localparam int PW = $clog2(N_REQ);

  logic [N_REQ-1:0]       req;
  logic [N_REQ*WIDTH-1:0] wdata;
  logic [N_REQ-1:0]       gnt;
  logic                   wr_en;
  logic [WIDTH-1:0]       q;
  logic [PW-1:0]          owner;
  logic                   busy;

  modport master (output req, wdata, input gnt, wr_en, q, owner, busy);
  modport slave  (input req, wdata, output gnt, wr_en, q, owner, busy);
endinterface

// File: rtl/dff_share_arbiter.sv
// Round-robin write arbiter for a shared enabled-flop register.
// Each accepted request costs one IDLE decision cycle and one GRANT cycle,
// followed by GAP cooldown cycles in which new requests are ignored.
module dff_share_arbiter #(
  parameter int N_REQ = 4,
  parameter int WIDTH = 8,
  parameter int GAP   = 1
) (
  input  logic               clk,
  input  logic               rst,
  dff_share_arbiter_if.slave bus
);
  localparam int PW = $clog2(N_REQ);

  typedef enum logic [1:0] {S_IDLE, S_GRANT, S_COOL} state_t;

  state_t           state_q, state_d;
  logic [N_REQ-1:0] gnt_q, gnt_d;
  logic [WIDTH-1:0] data_q, data_d;
  logic [WIDTH-1:0] q_q, q_d;
  logic [PW-1:0]    win_q, win_d;
  logic [PW-1:0]    owner_q, owner_d;
  logic [PW-1:0]    ptr_q, ptr_d;
  logic [3:0]       cnt_q, cnt_d;

  logic             found;
  logic [PW-1:0]    win;
  int               idx;

  // Rotating priority search: the first set request at or after ptr wins.
  always_comb begin
    found = 1'b0;
    win   = '0;
    idx   = 0;
    for (int i = 0; i < N_REQ; i++) begin
      idx = (int'(ptr_q) + i) % N_REQ;
      if (!found && bus.req[idx]) begin
        found = 1'b1;
        win   = PW'(idx);
      end
    end
  end

  // Next-state logic: decide in IDLE, write on the edge closing GRANT, then cool down.
  always_comb begin
    state_d = state_q;
    gnt_d   = gnt_q;
    data_d  = data_q;
    q_d     = q_q;
    win_d   = win_q;
    owner_d = owner_q;
    ptr_d   = ptr_q;
    cnt_d   = cnt_q;
    case (state_q)
      S_IDLE: begin
        if (found) begin
          // wdata is captured here, so later changes cannot disturb the write.
          data_d  = bus.wdata[win*WIDTH +: WIDTH];
          win_d   = win;
          gnt_d   = '0;
          gnt_d[win] = 1'b1;
          state_d = S_GRANT;
        end
      end
      S_GRANT: begin
        q_d     = data_q;
        owner_d = win_q;
        ptr_d   = (win_q == PW'(N_REQ - 1)) ? '0 : win_q + PW'(1);
        gnt_d   = '0;
        if (GAP > 0) begin
          cnt_d   = 4'(GAP - 1);
          state_d = S_COOL;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_COOL: begin
        if (cnt_q == 4'd0) state_d = S_IDLE;
        else               cnt_d   = cnt_q - 4'd1;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // State registers with synchronous active-low reset; a reset at the edge
  // closing GRANT wins over the pending write.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q <= S_IDLE;
      gnt_q   <= '0;
      data_q  <= '0;
      q_q     <= '0;
      win_q   <= '0;
      owner_q <= '0;
      ptr_q   <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      gnt_q   <= gnt_d;
      data_q  <= data_d;
      q_q     <= q_d;
      win_q   <= win_d;
      owner_q <= owner_d;
      ptr_q   <= ptr_d;
      cnt_q   <= cnt_d;
    end
  end

  assign bus.gnt   = gnt_q;
  assign bus.wr_en = |gnt_q;
  assign bus.q     = q_q;
  assign bus.owner = owner_q;
  assign bus.busy  = (state_q != S_IDLE);
endmodule

// File: tb/tb_dff_share_arbiter.sv
// Directed bench for dff_share_arbiter (N_REQ=4, WIDTH=8, GAP=1).
module tb_dff_share_arbiter;
  logic clk = 1'b0;
  logic rst;
  int   tests = 0;
  int   fails = 0;

  dff_share_arbiter_if #(.N_REQ(4), .WIDTH(8)) bus ();

  dff_share_arbiter #(.N_REQ(4), .WIDTH(8), .GAP(1)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  // Advance one rising edge, then settle 1 time unit past it.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  logic [7:0] rr_q [4] = '{8'h10, 8'h21, 8'h32, 8'h43};
  logic [3:0] rr_g [4] = '{4'b0001, 4'b0010, 4'b0100, 4'b1000};

  initial begin
    rst = 1'b0;
    bus.req   = 4'b1111;
    bus.wdata = {8'h43, 8'h32, 8'h21, 8'h10};

    // Reset held for two edges while every requester asks.
    step(); step();
    chk("rst_q",     32'(bus.q), 32'h0);
    chk("rst_gnt",   32'(bus.gnt), 32'h0);
    chk("rst_wr_en", 32'(bus.wr_en), 32'h0);
    chk("rst_busy",  32'(bus.busy), 32'h0);
    chk("rst_owner", 32'(bus.owner), 32'h0);
    rst = 1'b1;

    // Round robin with all requests held: order 0,1,2,3,0, three cycles apart.
    for (int g = 0; g < 5; g++) begin
      step();
      chk("rr_gnt",   32'(bus.gnt), 32'(rr_g[g % 4]));
      chk("rr_wr_en", 32'(bus.wr_en), 32'h1);
      chk("rr_busy",  32'(bus.busy), 32'h1);
      chk("rr_q_hold", 32'(bus.q), (g == 0) ? 32'h0 : 32'(rr_q[(g + 3) % 4]));
      if (g == 4) bus.req = 4'b0000;
      step();
      chk("rr_q",     32'(bus.q), 32'(rr_q[g % 4]));
      chk("rr_owner", 32'(bus.owner), 32'(g % 4));
      chk("rr_cool_busy", 32'(bus.busy), 32'h1);
      chk("rr_cool_gnt",  32'(bus.gnt), 32'h0);
      step();
      chk("rr_idle_busy", 32'(bus.busy), 32'h0);
      chk("rr_idle_gnt",  32'(bus.gnt), 32'h0);
    end

    // Single write from requester 2 (ptr is 1).
    bus.req = 4'b0100;
    bus.wdata[2*8 +: 8] = 8'hA5;
    step();
    chk("single_gnt",   32'(bus.gnt), 32'h4);
    chk("single_wr_en", 32'(bus.wr_en), 32'h1);
    chk("single_q_old", 32'(bus.q), 32'h10);
    bus.req = 4'b0000;
    step();
    chk("single_q",     32'(bus.q), 32'hA5);
    chk("single_owner", 32'(bus.owner), 32'h2);
    chk("single_busy",  32'(bus.busy), 32'h1);
    chk("single_wr_en0", 32'(bus.wr_en), 32'h0);
    step();
    chk("single_idle",  32'(bus.busy), 32'h0);

    // Requests raised only during COOLDOWN are ignored.
    bus.req = 4'b1000;
    bus.wdata[3*8 +: 8] = 8'h77;
    step();
    chk("cool_setup_gnt", 32'(bus.gnt), 32'h8);
    bus.req = 4'b0000;
    step();
    chk("cool_setup_q", 32'(bus.q), 32'h77);
    bus.req = 4'b0010;
    bus.wdata[1*8 +: 8] = 8'h99;
    step();
    chk("cool_ign_gnt",  32'(bus.gnt), 32'h0);
    chk("cool_ign_busy", 32'(bus.busy), 32'h0);
    bus.req = 4'b0000;
    step();
    chk("cool_ign_gnt2", 32'(bus.gnt), 32'h0);
    chk("cool_ign_q",    32'(bus.q), 32'h77);
    chk("cool_ign_own",  32'(bus.owner), 32'h3);

    // Reset on the edge closing GRANT aborts the write.
    bus.req = 4'b0010;
    bus.wdata[1*8 +: 8] = 8'hFF;
    step();
    chk("rstg_gnt", 32'(bus.gnt), 32'h2);
    bus.req = 4'b0000;
    rst = 1'b0;
    step();
    chk("rstg_q",     32'(bus.q), 32'h0);
    chk("rstg_gnt0",  32'(bus.gnt), 32'h0);
    chk("rstg_wr_en", 32'(bus.wr_en), 32'h0);
    chk("rstg_busy",  32'(bus.busy), 32'h0);
    chk("rstg_owner", 32'(bus.owner), 32'h0);
    rst = 1'b1;
    step();
    chk("rstg_idle_q", 32'(bus.q), 32'h0);

    // wdata changed during GRANT does not affect the write.
    bus.req = 4'b1000;
    bus.wdata[3*8 +: 8] = 8'h55;
    step();
    chk("samp_gnt", 32'(bus.gnt), 32'h8);
    bus.wdata[3*8 +: 8] = 8'hAA;
    bus.req = 4'b0000;
    step();
    chk("samp_q",     32'(bus.q), 32'h55);
    chk("samp_owner", 32'(bus.owner), 32'h3);
    step();
    chk("samp_idle",  32'(bus.busy), 32'h0);

    // Reset during COOLDOWN returns straight to quiet IDLE.
    bus.req = 4'b0001;
    bus.wdata[0*8 +: 8] = 8'h3C;
    step();
    chk("rstc_gnt", 32'(bus.gnt), 32'h1);
    bus.req = 4'b0000;
    step();
    chk("rstc_q", 32'(bus.q), 32'h3C);
    rst = 1'b0;
    step();
    chk("rstc_busy", 32'(bus.busy), 32'h0);
    chk("rstc_q0",   32'(bus.q), 32'h0);
    rst = 1'b1;
    step();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
